if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//  Fetch-stage controller; it is the consumer of the load-use stall signals (PC_write, IFID_write).
//  Owns the PC register, the instruction-memory request handshake, a one-entry hold buffer and the IF/ID register.
//  Obeys stalls, applies EX-stage branch/jump redirects (flush) and inserts NOP bubbles when imem is slow.
//  Sits between imem and the ID stage.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INSTR 32'h0000_0013  bubble encoding (addi x0,x0,0) driven on ifid_instr when invalid
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  rst          in   1   synchronous reset, active-high
//  PC_write     in   1   1 = PC may advance (from hazard unit)
//  IFID_write   in   1   1 = IF/ID register may load (from hazard unit)
//  flush        in   1   redirect taken in EX; squash fetch path
//  redirect_pc  in   32  target PC when flush=1; bits[1:0] ignored, forced 0
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  fetch address; stable while imem_req && !imem_ready
//  imem_ready   in   1   imem_rdata valid this cycle for imem_addr; completes request
//  imem_rdata   in   32  fetched instruction
//  ifid_pc      out  32  PC of instruction in IF/ID
//  ifid_instr   out  32  instruction in IF/ID (NOP_INSTR when ifid_valid=0)
//  ifid_valid   out  1   IF/ID holds a real instruction
//  fetch_stall  out  1   1 = FETCH waiting on imem (imem_req && !imem_ready)
// BEHAVIOUR
//  Reset (rst=1 at edge): pc=RESET_PC, state=FETCH, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0,
//    hold buffer empty, pend_pc=0. During the rst cycle imem_req=0 and fetch_stall=0.
//  States: FETCH, HOLD, DROP. imem_addr = pc in FETCH; = old pc in DROP.
//  FETCH: imem_req=1.
//    ready && IFID_write: IF/ID <= {pc, rdata, valid=1}; pc<=pc+4 if PC_write.
//    ready && !IFID_write: rdata,pc -> hold buffer; go HOLD; pc unchanged.
//    !ready && IFID_write: IF/ID <= bubble (valid=0, NOP_INSTR); pc unchanged.
//    !ready && !IFID_write: IF/ID keeps its value.
//  HOLD: imem_req=0. When IFID_write=1: IF/ID <= buffer (valid=1); pc<=pc+4 if PC_write; go FETCH.
//  DROP: imem_req=1 on the abandoned address (never withdrawn mid-transaction).
//    On ready: discard rdata; pc<=pend_pc; go FETCH. IF/ID stays bubble throughout.
//  Latency: ready at edge N -> ifid_valid/ifid_instr visible after edge N; next request in cycle N+1.
//  flush=1 overrides stall and every other input in any state:
//    IF/ID <= bubble; hold buffer cleared.
//    If FETCH && imem_req && !imem_ready: pend_pc<=redirect_pc, go DROP.
//    Otherwise: pc<=redirect_pc, go FETCH.
//    A flush while in DROP updates pend_pc (latest redirect wins).
//  PC_write=1 with IFID_write=0 is treated as a stall (pc holds); the hazard unit drives them together.
//  pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); no overflow flag.
//  fetch_stall is combinational from state and imem_ready; all other outputs are registered except imem_req/imem_addr.
//  rst mid-transaction: request abandoned, no DROP; imem must tolerate a re-issued address after reset.
// STRUCTURE
//  Shared package pipe_pkg: NOP_INSTR constant, fetch state encoding (FETCH=2'd0, HOLD=2'd1, DROP=2'd2), XLEN=32.
//  One sub-module: fetch_hold_buf (1-entry {pc,instr,valid} register with load/clear/drain).
//  FSM, PC register and IF/ID register stay in this module.
// TESTING
//  1 Reset, imem_ready=1 always, no stalls -> imem_addr 0,4,8,...; ifid_pc trails imem_addr by one cycle; ifid_valid=1 from the 2nd edge.
//  2 Load-use stall: PC_write=IFID_write=0 for 1 cycle while ready -> HOLD; buffered instr appears at IF/ID next
//    cycle with no duplicate or lost PC.
//  3 imem_ready low 3 cycles at 0x10 -> imem_addr held at 0x10, fetch_stall=1, three bubbles (NOP, valid=0),
//    then 0x10 delivered.
//  4 flush redirect_pc=0x200 while 0x14 outstanding and not ready -> DROP; 0x14 data discarded on ready;
//    next imem_addr=0x200; no valid instr from 0x14.
//  5 flush and IFID_write=0 in the same cycle while in HOLD -> buffer cleared, pc=0x200, FETCH, ifid_valid=0.
//  6 pc=0xFFFF_FFFC fetched -> next imem_addr=0x0; rst asserted mid-DROP -> pc=RESET_PC, ifid_valid=0.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared pipeline definitions for the fetch stage: widths, bubble encoding,
// fetch FSM state encoding and the IF/ID payload layout.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

  // Instruction addresses are word aligned; low bits of a redirect are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch controller
// (master) and the instruction memory (slave).
interface if_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_ctrl_hold_buf.sv
// One-entry buffer that parks a fetched instruction while ID is stalled.
// Priority: clear over load over drain.
module fetch_hold_buf
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic            drain_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);

  ifid_t buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (clear_i) begin
      buf_d = '0;
    end else if (load_i) begin
      buf_d.pc    = pc_i;
      buf_d.instr = instr_i;
      buf_d.valid = 1'b1;
    end else if (drain_i) begin
      buf_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign pc_o    = buf_q.pc;
  assign instr_o = buf_q.instr;
  assign valid_o = buf_q.valid;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: PC register, imem handshake, hold buffer and IF/ID
// register, honouring load-use stalls, EX redirects and slow-imem bubbles.
module if_fetch_ctrl #(
  parameter logic [pipe_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [pipe_pkg::XLEN-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      PC_write,
  input  logic                      IFID_write,
  input  logic                      flush,
  input  logic [pipe_pkg::XLEN-1:0] redirect_pc,
  if_fetch_ctrl_if.master           imem,
  output logic [pipe_pkg::XLEN-1:0] ifid_pc,
  output logic [pipe_pkg::XLEN-1:0] ifid_instr,
  output logic                      ifid_valid,
  output logic                      fetch_stall
);
  import pipe_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  ifid_t           ifid_q, ifid_d;
  ifid_t           bubble;

  logic            req_c;
  logic            buf_load, buf_clear, buf_drain;
  logic [XLEN-1:0] buf_pc, buf_instr;
  logic            buf_valid;

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .drain_i (buf_drain),
    .pc_i    (pc_q),
    .instr_i (imem.imem_rdata),
    .pc_o    (buf_pc),
    .instr_o (buf_instr),
    .valid_o (buf_valid)
  );

  // In DROP pc_q still holds the abandoned address, so imem_addr stays stable.
  assign req_c          = !rst && (state_q == FETCH || state_q == DROP);
  assign imem.imem_req  = req_c;
  assign imem.imem_addr = pc_q;
  assign fetch_stall    = req_c && !imem.imem_ready;

  always_comb begin
    bubble       = ifid_q;
    bubble.instr = NOP_INSTR;
    bubble.valid = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    ifid_d    = ifid_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    buf_drain = 1'b0;

    if (flush) begin
      ifid_d    = bubble;
      buf_clear = 1'b1;
      // An outstanding request cannot be withdrawn: finish it in DROP.
      if (req_c && !imem.imem_ready) begin
        pend_pc_d = align_pc(redirect_pc);
        state_d   = DROP;
      end else begin
        pc_d    = align_pc(redirect_pc);
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.imem_ready) begin
            if (IFID_write) begin
              ifid_d.pc    = pc_q;
              ifid_d.instr = imem.imem_rdata;
              ifid_d.valid = 1'b1;
              if (PC_write) pc_d = pc_q + 32'd4;
            end else begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end
          end else if (IFID_write) begin
            ifid_d = bubble;
          end
        end
        HOLD: begin
          if (IFID_write) begin
            ifid_d.pc    = buf_pc;
            ifid_d.instr = buf_instr;
            ifid_d.valid = buf_valid;
            buf_drain    = 1'b1;
            if (PC_write) pc_d = pc_q + 32'd4;
            state_d = FETCH;
          end
        end
        DROP: begin
          ifid_d = bubble;
          if (imem.imem_ready) begin
            pc_d    = pend_pc_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      ifid_q.pc    <= '0;
      ifid_q.instr <= NOP_INSTR;
      ifid_q.valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      ifid_q    <= ifid_d;
    end
  end

  assign ifid_pc    = ifid_q.pc;
  assign ifid_instr = ifid_q.instr;
  assign ifid_valid = ifid_q.valid;

endmodule
